// File: rtl/excess3_pkg.sv
// rtl/excess3_pkg.sv - shared types and constants for the Excess-3/BCD codec
// Contents: FSM state enum, direction (mode) encodings, digit range limits,
// and the code substituted for an invalid digit.
package excess3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_XS3_TO_BCD = 1'b0;
  localparam logic MODE_BCD_TO_XS3 = 1'b1;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] ERR_DIGIT  = 4'hF;

endpackage

// File: rtl/excess3_digit_conv.sv
// rtl/excess3_digit_conv.sv - combinational single-digit Excess-3/BCD converter
// Ports:
//   code    in  4 : digit to convert
//   mode    in  1 : 0 = Excess-3 to BCD, 1 = BCD to Excess-3
//   result  out 4 : converted digit, ERR_DIGIT when code is out of range
//   invalid out 1 : code is not a legal digit for the selected mode
module excess3_digit_conv
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  input  logic       mode,
  output logic [3:0] result,
  output logic       invalid
);

  always_comb begin
    result  = ERR_DIGIT;
    invalid = 1'b1;
    if (mode == MODE_XS3_TO_BCD) begin
      if (code >= XS3_MIN && code <= XS3_MAX) begin
        result  = code - XS3_OFFSET;
        invalid = 1'b0;
      end
    end else begin
      if (code <= BCD_MAX) begin
        result  = code + XS3_OFFSET;
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/excess3_bcd_codec.sv
// rtl/excess3_bcd_codec.sv - serial multi-digit Excess-3/BCD converter
// Converts one digit per clock through a single shared digit converter.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready, in_mode, in_data   : input word handshake
//   out_valid/out_ready, out_data         : result word handshake
//   out_err_mask  : per-digit invalid flags; out_err is their OR
module excess3_bcd_codec
  import excess3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [W-1:0]      cap_data_q;
  logic              cap_mode_q;
  logic [W-1:0]      res_q;
  logic [DIGITS-1:0] mask_q;

  logic [3:0]        cur_code;
  logic [3:0]        cur_res;
  logic              cur_bad;
  logic              last_digit;

  // Index-selected digit feeding the shared converter.
  always_comb begin
    cur_code = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_code = cap_data_q[i*4 +: 4];
    end
  end

  excess3_digit_conv u_digit_conv (
    .code    (cur_code),
    .mode    (cap_mode_q),
    .result  (cur_res),
    .invalid (cur_bad)
  );

  assign last_digit = (idx_q == IW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = CONV;
      CONV:    if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, then fill one result digit per CONV cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      cap_data_q <= '0;
      cap_mode_q <= 1'b0;
      res_q      <= '0;
      mask_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cap_data_q <= in_data;
            cap_mode_q <= in_mode;
            res_q      <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
          end
        end
        CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
              res_q[i*4 +: 4] <= cur_res;
              mask_q[i]       <= cur_bad;
            end
          end
          if (!last_digit) idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs depend on registered state only.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_data     = res_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

endmodule

// File: tb/tb_excess3_bcd_codec.sv
// tb/tb_excess3_bcd_codec.sv - self-checking bench for excess3_bcd_codec
module tb_excess3_bcd_codec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_mode;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_err_mask;
  logic        out_err;

  logic        iv1, ir1, im1, ov1, or1, oe1;
  logic [3:0]  id1, od1;
  logic [0:0]  om1;

  logic        iv16, ir16, im16, ov16, or16, oe16;
  logic [63:0] id16, od16;
  logic [15:0] om16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  excess3_bcd_codec #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_mask(out_err_mask), .out_err(out_err)
  );

  excess3_bcd_codec #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .in_mode(im1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_err_mask(om1), .out_err(oe1)
  );

  excess3_bcd_codec #(.DIGITS(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16), .in_mode(im16), .in_data(id16),
    .out_valid(ov16), .out_ready(or16), .out_data(od16),
    .out_err_mask(om16), .out_err(oe16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: returns {mask[3:0], data[15:0]} using plain integer arithmetic.
  function automatic logic [19:0] model_conv(input logic [15:0] d, input logic m);
    logic [15:0] r;
    logic [3:0]  mk;
    r  = '0;
    mk = '0;
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'(d[i*4 +: 4]);
      if (m == 1'b0) begin
        if (v >= 3 && v <= 12) r[i*4 +: 4] = 4'(v - 3);
        else begin r[i*4 +: 4] = 4'hF; mk[i] = 1'b1; end
      end else begin
        if (v <= 9) r[i*4 +: 4] = 4'(v + 3);
        else begin r[i*4 +: 4] = 4'hF; mk[i] = 1'b1; end
      end
    end
    return {mk, r};
  endfunction

  // Transaction-level model of the 4-digit instance: busy flag, cycles
  // since accept, and the expected result word.
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [19:0] m_exp  = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else begin
      check("mdl_in_ready", in_ready, !m_busy);
      check("mdl_out_valid", out_valid, (m_busy && m_cnt >= 4));
      if (m_busy && m_cnt >= 4) begin
        check("mdl_out_data", out_data, m_exp[15:0]);
        check("mdl_out_mask", out_err_mask, m_exp[19:16]);
        check("mdl_out_err", out_err, |m_exp[19:16]);
      end
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_exp  = model_conv(in_data, in_mode);
        end
      end else if (m_cnt >= 4) begin
        if (out_ready) m_busy = 1'b0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic m);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_mode = m;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    if (!out_valid) check("wait_out_timeout", 0, 1);
  endtask

  task automatic expect_word(input string name, input logic [15:0] d, input logic m,
                             input logic [15:0] ed, input logic [3:0] em);
    int k;
    out_ready = 1'b0;
    send(d, m);
    wait_out(k);
    check({name, "_latency"}, 64'(k - 1), 64'd4);
    check({name, "_data"}, out_data, ed);
    check({name, "_mask"}, out_err_mask, em);
    check({name, "_err"}, out_err, |em);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    iv1 = 1'b0; im1 = 1'b0; id1 = '0; or1 = 1'b1;
    iv16 = 1'b0; im16 = 1'b0; id16 = '0; or16 = 1'b1;

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mask", out_err_mask, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed values pinning the reference model.
    check("model_4C37_m0", model_conv(16'h4C37, 1'b0), {4'b0000, 16'h1904});
    check("model_1904_m1", model_conv(16'h1904, 1'b1), {4'b0000, 16'h4C37});
    check("model_3D20_m0", model_conv(16'h3D20, 1'b0), {4'b0111, 16'h0FFF});
    check("model_A009_m1", model_conv(16'hA009, 1'b1), {4'b1000, 16'hF33C});

    expect_word("xs3_to_bcd", 16'h4C37, 1'b0, 16'h1904, 4'b0000);
    expect_word("bcd_to_xs3", 16'h1904, 1'b1, 16'h4C37, 4'b0000);
    expect_word("bad_m0", 16'h3D20, 1'b0, 16'h0FFF, 4'b0111);
    expect_word("bad_m1", 16'hA009, 1'b1, 16'hF33C, 4'b1000);

    // Backpressure with a second word waiting.
    out_ready = 1'b0;
    send(16'h1904, 1'b1);
    wait_out(k);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h4C37; in_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 16'h4C37);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(k);
    check("bp_second_data", out_data, 16'h1904);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // Reset in the middle of a conversion.
    send(16'h4C37, 1'b0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_mask", out_err_mask, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
    end
    expect_word("after_rst", 16'h4C37, 1'b0, 16'h1904, 4'b0000);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      in_mode   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b0;

    // DIGITS=1 instance.
    @(posedge clk); #1;
    iv1 = 1'b1; id1 = 4'h5; im1 = 1'b0;
    @(negedge clk);
    check("d1_in_ready", ir1, 1);
    @(posedge clk); #1 iv1 = 1'b0;
    k = 1;
    @(negedge clk);
    while (!ov1 && k < 50) begin @(negedge clk); k++; end
    check("d1_latency", 64'(k - 1), 64'd1);
    check("d1_data", od1, 4'h2);
    check("d1_mask", om1, 1'b0);

    // DIGITS=16 instance.
    @(posedge clk); #1;
    iv16 = 1'b1; id16 = {16{4'h3}}; im16 = 1'b0;
    @(negedge clk);
    check("d16_in_ready", ir16, 1);
    @(posedge clk); #1 iv16 = 1'b0;
    k = 1;
    @(negedge clk);
    while (!ov16 && k < 50) begin @(negedge clk); k++; end
    check("d16_latency", 64'(k - 1), 64'd16);
    check("d16_data", od16, 64'h0);
    check("d16_mask", om16, 16'h0);
    check("d16_err", oe16, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
